// File: rtl/cond_counter_pkg.sv
// Shared constants and elaboration helpers for the conditional-update counter bank.
package cond_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Readback select width: a single channel still gets a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/cond_counter_chan.sv
// One counter channel: load/increment next-state logic with wrap or clamp,
// terminal-count pulse and sticky saturation flag.
module cond_counter_chan
  import cond_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int INIT     = 0,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             sat_flag
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH:0]   sum_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             sat_r;
  logic             sat_nxt_s;

  // Next-state selection: clear > load > increment > hold.
  always_comb begin
    sum_s       = {1'b0, count_r} + STEP_EXT;
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    sat_nxt_s   = sat_r;
    if (clear) begin
      count_nxt_s = INIT_VAL;
      sat_nxt_s   = 1'b0;
    end else if (load_en) begin
      count_nxt_s = load_val;
    end else if (inc_en) begin
      if (SATURATE == MODE_SAT) begin
        // The carry bit marks a sum beyond the representable maximum.
        if (sum_s[WIDTH]) begin
          count_nxt_s = MAX_VAL;
          sat_nxt_s   = 1'b1;
          tc_nxt_s    = (count_r != MAX_VAL);
        end else begin
          count_nxt_s = sum_s[WIDTH-1:0];
          tc_nxt_s    = (sum_s[WIDTH-1:0] == MAX_VAL);
        end
      end else begin
        count_nxt_s = sum_s[WIDTH-1:0];
        tc_nxt_s    = sum_s[WIDTH];
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers with synchronous reset to the init value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= INIT_VAL;
      tc_r    <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  assign count    = count_r;
  assign tc_pulse = tc_r;
  assign sat_flag = sat_r;

endmodule

// File: rtl/cond_update_counter_bank.sv
// Bank of N_CH independent conditionally-updated counters with a registered,
// zero-extended readback of one selected channel.
module cond_update_counter_bank
  import cond_counter_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int INIT     = 0,
  parameter int SATURATE = MODE_WRAP,
  parameter int OUT_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              inc_en,
  input  logic [N_CH-1:0]              load_en,
  input  logic [N_CH*WIDTH-1:0]        load_val,
  input  logic                         clear,
  input  logic [sel_width(N_CH)-1:0]   sel,
  output logic [OUT_W-1:0]             rd_data,
  output logic [N_CH*WIDTH-1:0]        cnt_flat,
  output logic [N_CH-1:0]              tc_pulse,
  output logic [N_CH-1:0]              sat_flag
);

  localparam int SEL_W = sel_width(N_CH);

  logic [WIDTH-1:0] cnt_arr_s [N_CH];
  logic [OUT_W-1:0] rd_nxt_s;
  logic [OUT_W-1:0] rd_data_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    cond_counter_chan #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .INIT     (INIT),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .inc_en   (inc_en[g]),
      .load_en  (load_en[g]),
      .load_val (load_val[slice_lo(g, WIDTH) +: WIDTH]),
      .count    (cnt_arr_s[g]),
      .tc_pulse (tc_pulse[g]),
      .sat_flag (sat_flag[g])
    );
    assign cnt_flat[slice_lo(g, WIDTH) +: WIDTH] = cnt_arr_s[g];
  end

  // Readback mux; an out-of-range select matches no channel and reads zero.
  always_comb begin
    rd_nxt_s = {OUT_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      rd_nxt_s = (sel == SEL_W'(i)) ? OUT_W'(cnt_arr_s[i]) : rd_nxt_s;
    end
  end

  // Readback register samples the current (pre-update) counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {OUT_W{1'b0}};
    end else begin
      rd_data_r <= rd_nxt_s;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: tb/tb_cond_update_counter_bank.sv
// Scoreboard bench: a wrap-mode bank (4 ch, STEP 1) and a saturate-mode bank
// (3 ch, STEP 3) share stimulus and are checked against an integer model.
module tb_cond_update_counter_bank;

  localparam int NA = 4;
  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  inc_en = 4'd0;
  logic [3:0]  load_en = 4'd0;
  logic [31:0] load_val = 32'd0;
  logic [1:0]  sel = 2'd0;

  logic [31:0] rd_a, rd_b;
  logic [31:0] cnt_a;
  logic [23:0] cnt_b;
  logic [3:0]  tc_a, sat_a;
  logic [2:0]  tc_b, sat_b;

  typedef struct packed {
    logic [1:0][31:0] rd;
    logic [1:0][31:0] cnt;
    logic [1:0][3:0]  tc;
    logic [1:0][3:0]  sat;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt [2][4];
  bit   m_tc  [2][4];
  bit   m_sat [2][4];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cond_update_counter_bank #(
    .N_CH(NA), .WIDTH(8), .STEP(1), .INIT(0), .SATURATE(0), .OUT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .inc_en(inc_en), .load_en(load_en),
    .load_val(load_val), .clear(clear), .sel(sel), .rd_data(rd_a),
    .cnt_flat(cnt_a), .tc_pulse(tc_a), .sat_flag(sat_a)
  );

  cond_update_counter_bank #(
    .N_CH(NB), .WIDTH(8), .STEP(3), .INIT(0), .SATURATE(1), .OUT_W(32)
  ) dut_b (
    .clk(clk), .reset(reset), .inc_en(inc_en[2:0]), .load_en(load_en[2:0]),
    .load_val(load_val[23:0]), .clear(clear), .sel(sel), .rd_data(rd_b),
    .cnt_flat(cnt_b), .tc_pulse(tc_b), .sat_flag(sat_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counts as plain integers, 8-bit range 0..255.
  task automatic model_step(input logic rst, input logic clr, input logic [3:0] inc,
                            input logic [3:0] ld, input logic [31:0] lv, input logic [1:0] s);
    exp_t e;
    e = '0;
    for (int d = 0; d < 2; d++) begin
      int n;
      int stp;
      int sum;
      n   = (d == 0) ? NA : NB;
      stp = (d == 0) ? 1 : 3;
      e.rd[d] = (!rst && int'(s) < n) ? 32'(m_cnt[d][s]) : 32'd0;
      for (int i = 0; i < n; i++) begin
        m_tc[d][i] = 1'b0;
        if (rst || clr) begin
          m_cnt[d][i] = 0;
          m_sat[d][i] = 1'b0;
        end else if (ld[i]) begin
          m_cnt[d][i] = int'(lv[i*8 +: 8]);
        end else if (inc[i]) begin
          sum = m_cnt[d][i] + stp;
          if (d == 1) begin
            if (sum > 255) begin
              m_tc[d][i]  = (m_cnt[d][i] != 255);
              m_cnt[d][i] = 255;
              m_sat[d][i] = 1'b1;
            end else begin
              m_tc[d][i]  = (sum == 255);
              m_cnt[d][i] = sum;
            end
          end else begin
            m_tc[d][i]  = (sum > 255);
            m_cnt[d][i] = sum % 256;
          end
        end
        e.cnt[d][i*8 +: 8] = 8'(m_cnt[d][i]);
        e.tc[d][i]  = m_tc[d][i];
        e.sat[d][i] = m_sat[d][i];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic clr, input logic [3:0] inc,
                       input logic [3:0] ld, input logic [31:0] lv, input logic [1:0] s);
    @(posedge clk);
    #2;
    reset    = rst;
    clear    = clr;
    inc_en   = inc;
    load_en  = ld;
    load_val = lv;
    sel      = s;
    model_step(rst, clr, inc, ld, lv, s);
  endtask

  // Monitor: every edge presents a new bank state; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wrap_cnt", cnt_a, e.cnt[0]);
        check("wrap_tc",  {28'd0, tc_a}, {28'd0, e.tc[0]});
        check("wrap_sat", {28'd0, sat_a}, {28'd0, e.sat[0]});
        check("wrap_rd",  rd_a, e.rd[0]);
        check("sat_cnt",  {8'd0, cnt_b}, e.cnt[1]);
        check("sat_tc",   {29'd0, tc_b}, {28'd0, e.tc[1]});
        check("sat_sat",  {29'd0, sat_b}, {28'd0, e.sat[1]});
        check("sat_rd",   rd_b, e.rd[1]);
      end
    end
  end

  initial begin
    // Reset held with increments requested.
    drive(1'b1, 1'b0, 4'hF, 4'h0, 32'd0, 2'd0);
    drive(1'b1, 1'b0, 4'hF, 4'h0, 32'd0, 2'd0);
    // Wrap/saturate boundaries: ch0 = 0xFE, ch1 = 0xFB, then three increments.
    drive(1'b0, 1'b0, 4'h0, 4'b0011, 32'h0000FBFE, 2'd0);
    repeat (3) drive(1'b0, 1'b0, 4'b0011, 4'h0, 32'd0, 2'd1);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd1);
    // Load beats increment; clear beats load.
    drive(1'b0, 1'b0, 4'b0100, 4'b0100, 32'h00550000, 2'd2);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd2);
    drive(1'b0, 1'b1, 4'hF, 4'hF, 32'hA5A5A5A5, 2'd2);
    // Readback of ch3 and of an out-of-range select on the 3-channel bank.
    drive(1'b0, 1'b0, 4'h0, 4'b1000, 32'h7A000000, 2'd3);
    repeat (2) drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd3);
    // Independence from a cleared state.
    drive(1'b0, 1'b1, 4'h0, 4'h0, 32'd0, 2'd0);
    repeat (5) drive(1'b0, 1'b0, 4'b1010, 4'h0, 32'd0, 2'd1);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd3);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd0);
    // Randomised traffic with occasional loads, clears and resets.
    for (int k = 0; k < 600; k++) begin
      logic [3:0]  ld;
      logic [31:0] lv;
      lv = $urandom;
      ld = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 7) == 0) begin
        lv = lv | 32'hF8F8F8F8;
      end
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            4'($urandom), ld, lv, 2'($urandom));
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 2'd0);
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
